// File: rtl/ahblite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahblite_pkg
// Description : Shared AHB-Lite encodings and the address-phase bundle used
//               by the two-master bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ahblite_pkg;

  // Transfer type encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address-phase field widths
  localparam int ADDR_W  = 32;
  localparam int TRANS_W = 2;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 3;
  localparam int PROT_W  = 4;
  localparam int HOLD_W  = ADDR_W + TRANS_W + 1 + SIZE_W + BURST_W + PROT_W + 1;

  // One master's complete address phase (46 bits)
  typedef struct packed {
    logic [ADDR_W-1:0]  haddr;
    logic [TRANS_W-1:0] htrans;
    logic               hwrite;
    logic [SIZE_W-1:0]  hsize;
    logic [BURST_W-1:0] hburst;
    logic [PROT_W-1:0]  hprot;
    logic               hmastlock;
  } addr_phase_t;

endpackage
`default_nettype wire

// File: rtl/ahblite_arb_hold.sv
`default_nettype none
// ============================================================================
// Module      : ahblite_arb_hold
// Description : Per-master address-phase holding register. Captures a
//               transfer the shared bus could not take this cycle and
//               replays it once this master owns the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module ahblite_arb_hold
  import ahblite_pkg::*;
#(
  parameter logic MIDX = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  addr_phase_t live_i,
  input  logic        grant_i,
  input  logic        bus_hready_i,
  input  logic        m_hready_i,
  output addr_phase_t sel_o,
  output logic        req_o,
  output logic        hold_v_o
);

  logic [HOLD_W-1:0] hold_q;
  logic              hold_v_q;
  logic              capture;
  logic              issue;

  // A transfer is captured unless it goes straight onto the shared bus;
  // capture needs m_hready_i=1, which a pending hold forces low, so capture
  // and issue never coincide.
  assign capture = m_hready_i && live_i.htrans[1] && !((grant_i == MIDX) && bus_hready_i);
  assign issue   = (grant_i == MIDX) && hold_v_q && bus_hready_i;

  // Holding register and its valid flag
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_v_q <= 1'b0;
    end else if (capture) begin
      hold_q   <= live_i;
      hold_v_q <= 1'b1;
    end else if (issue) begin
      hold_v_q <= 1'b0;
    end
  end

  assign sel_o    = hold_v_q ? addr_phase_t'(hold_q) : live_i;
  assign req_o    = hold_v_q || ((live_i.htrans == HTRANS_NONSEQ) && m_hready_i);
  assign hold_v_o = hold_v_q;

endmodule
`default_nettype wire

// File: rtl/ahblite_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahblite_bus_arbiter
// Description : Two-master AHB-Lite arbiter/multiplexer. Drives the shared
//               address and write-data bus and steers HREADY/HRESP back to
//               the master owning the current data phase.
// Revision    : 1.0 - initial release
// ============================================================================
module ahblite_bus_arbiter
  import ahblite_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned RESET_GRANT = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HRESP,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HRESP,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  output logic        HMASTER,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  logic        grant_q, grant_d;
  logic        data_valid_q;
  logic        data_owner_q;
  addr_phase_t live [2];
  addr_phase_t sel  [2];
  addr_phase_t bus;
  logic [1:0]  req;
  logic [1:0]  hold_v;
  logic [1:0]  m_hready;
  logic        keep;
  logic        other;

  assign live[0] = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK};
  assign live[1] = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK};

  generate
    for (genvar m = 0; m < 2; m++) begin : g_hold
      ahblite_arb_hold #(
        .MIDX (m != 0)
      ) u_hold (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .live_i       (live[m]),
        .grant_i      (grant_q),
        .bus_hready_i (HREADY),
        .m_hready_i   (m_hready[m]),
        .sel_o        (sel[m]),
        .req_o        (req[m]),
        .hold_v_o     (hold_v[m])
      );
    end
  endgenerate

  // Ready/response steering: the data-phase owner sees the slave, a master
  // with a pending hold is stalled, anyone else sees an idle-ready bus.
  assign m_hready[0] = (data_valid_q && !data_owner_q) ? HREADY : !hold_v[0];
  assign m_hready[1] = (data_valid_q &&  data_owner_q) ? HREADY : !hold_v[1];
  assign M0_HREADY   = m_hready[0];
  assign M1_HREADY   = m_hready[1];
  assign M0_HRESP    = (data_valid_q && !data_owner_q) ? HRESP : HRESP_OKAY;
  assign M1_HRESP    = (data_valid_q &&  data_owner_q) ? HRESP : HRESP_OKAY;
  assign M0_HRDATA   = HRDATA;
  assign M1_HRDATA   = HRDATA;
  assign HWDATA      = data_owner_q ? M1_HWDATA : M0_HWDATA;

  assign bus       = grant_q ? sel[1] : sel[0];
  assign HADDR     = bus.haddr;
  assign HTRANS    = bus.htrans;
  assign HWRITE    = bus.hwrite;
  assign HSIZE     = bus.hsize;
  assign HBURST    = bus.hburst;
  assign HPROT     = bus.hprot;
  assign HMASTLOCK = bus.hmastlock;
  assign HMASTER   = grant_q;
  assign other     = ~grant_q;

  // Next grant: bursts and locked sequences keep the bus, otherwise arbitrate
  always_comb begin
    grant_d = grant_q;
    keep    = (bus.htrans == HTRANS_SEQ) || (bus.htrans == HTRANS_BUSY) ||
              ((bus.htrans == HTRANS_NONSEQ) && (bus.hburst != HBURST_SINGLE)) ||
              bus.hmastlock;
    if (!keep) begin
      if (ROUND_ROBIN != 0) begin
        if (req[other]) grant_d = other;
      end else begin
        if (req[0])      grant_d = 1'b0;
        else if (req[1]) grant_d = 1'b1;
      end
    end
  end

  // Grant and data-phase tracking advance only on completed bus cycles
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q      <= RESET_GRANT[0];
      data_valid_q <= 1'b0;
      data_owner_q <= 1'b0;
    end else if (HREADY) begin
      grant_q      <= grant_d;
      data_valid_q <= bus.htrans[1];
      data_owner_q <= grant_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahblite_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahblite_bus_arbiter
// Description : Self-checking bench for ahblite_bus_arbiter. Expected bus
//               observations are queued per cycle and compared at negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahblite_bus_arbiter;
  import ahblite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [2:0]  M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic        M0_HMASTLOCK, M1_HMASTLOCK;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        M0_HREADY, M1_HREADY;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        M0_HRESP, M1_HRESP;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HMASTER;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  localparam int K_HADDR  = 0;
  localparam int K_HTRANS = 1;
  localparam int K_HMAST  = 2;
  localparam int K_M0RDY  = 3;
  localparam int K_M1RDY  = 4;
  localparam int K_M0RESP = 5;
  localparam int K_M1RESP = 6;
  localparam int K_HWDATA = 7;
  localparam int K_M0RDAT = 8;
  localparam int K_HWRITE = 9;

  localparam logic [2:0] INCR4 = 3'b011;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_pass  = 0;
  int n_total = 0;

  ahblite_bus_arbiter #(.ROUND_ROBIN(1), .RESET_GRANT(0)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HMASTER(HMASTER),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_HADDR:  return HADDR;
      K_HTRANS: return {30'd0, HTRANS};
      K_HMAST:  return {31'd0, HMASTER};
      K_M0RDY:  return {31'd0, M0_HREADY};
      K_M1RDY:  return {31'd0, M1_HREADY};
      K_M0RESP: return {31'd0, M0_HRESP};
      K_M1RESP: return {31'd0, M1_HRESP};
      K_HWDATA: return HWDATA;
      K_M0RDAT: return M0_HRDATA;
      default:  return {31'd0, HWRITE};
    endcase
  endfunction

  task automatic expect_obs(input int kind, input string tag, input logic [31:0] val);
    sb_item_t it;
    it.tag  = tag;
    it.kind = kind;
    it.exp  = val;
    sb_q.push_back(it);
  endtask

  // Compare everything queued for this cycle, then advance one clock
  task automatic tick();
    sb_item_t it;
    @(negedge HCLK);
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check_val(it.tag, observe(it.kind), it.exp);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_m0(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic [2:0] bu);
    M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = wr; M0_HBURST = bu;
  endtask

  task automatic drive_m1(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic [2:0] bu);
    M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = wr; M1_HBURST = bu;
  endtask

  task automatic idle_both();
    drive_m0(HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
    drive_m1(HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
  endtask

  initial begin
    HRESET = 1'b1;
    M0_HSIZE = 3'b010; M1_HSIZE = 3'b010; M0_HPROT = 4'b0011; M1_HPROT = 4'b0011;
    M0_HMASTLOCK = 1'b0; M1_HMASTLOCK = 1'b0;
    M0_HWDATA = 32'h0A0A0A0A; M1_HWDATA = 32'h0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    idle_both();
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Reset state
    expect_obs(K_M0RDY, "rst_m0rdy", 1); expect_obs(K_M1RDY, "rst_m1rdy", 1);
    expect_obs(K_M0RESP, "rst_m0resp", 0); expect_obs(K_M1RESP, "rst_m1resp", 0);
    expect_obs(K_HMAST, "rst_hmaster", 0);
    tick();

    // A: granted M0 single read goes straight to the bus
    drive_m0(HTRANS_NONSEQ, 32'h20000010, 1'b0, HBURST_SINGLE);
    expect_obs(K_HADDR, "a0_haddr", 32'h20000010); expect_obs(K_HTRANS, "a0_htrans", 2);
    expect_obs(K_M0RDY, "a0_m0rdy", 1); expect_obs(K_HMAST, "a0_hmaster", 0);
    tick();
    idle_both(); HRDATA = 32'hCAFE0001;
    expect_obs(K_M0RDY, "a1_m0rdy", 1); expect_obs(K_M0RDAT, "a1_rdata", 32'hCAFE0001);
    expect_obs(K_HTRANS, "a1_htrans", 0);
    tick();

    // B: simultaneous NONSEQ, M1 write captured and replayed next cycle
    drive_m0(HTRANS_NONSEQ, 32'h00000100, 1'b0, HBURST_SINGLE);
    drive_m1(HTRANS_NONSEQ, 32'h40000000, 1'b1, HBURST_SINGLE);
    expect_obs(K_HADDR, "b0_haddr", 32'h00000100); expect_obs(K_HMAST, "b0_hmaster", 0);
    expect_obs(K_M0RDY, "b0_m0rdy", 1); expect_obs(K_M1RDY, "b0_m1rdy", 1);
    tick();
    idle_both(); M1_HWDATA = 32'hD1D1D1D1;
    expect_obs(K_HADDR, "b1_haddr", 32'h40000000); expect_obs(K_HTRANS, "b1_htrans", 2);
    expect_obs(K_HMAST, "b1_hmaster", 1); expect_obs(K_M1RDY, "b1_m1rdy", 0);
    expect_obs(K_M0RDY, "b1_m0rdy", 1); expect_obs(K_HWDATA, "b1_hwdata", 32'h0A0A0A0A);
    tick();
    expect_obs(K_M1RDY, "b2_m1rdy", 1); expect_obs(K_HMAST, "b2_hmaster", 1);
    expect_obs(K_HWDATA, "b2_hwdata", 32'hD1D1D1D1);
    tick();

    // C: M0 INCR4 burst (grant first moves from M1), M1 request during beat 2
    drive_m0(HTRANS_NONSEQ, 32'h20000000, 1'b0, INCR4);
    expect_obs(K_HMAST, "c0_hmaster", 1); expect_obs(K_HTRANS, "c0_htrans", 0);
    expect_obs(K_M0RDY, "c0_m0rdy", 1);
    tick();
    drive_m0(HTRANS_SEQ, 32'h20000004, 1'b0, INCR4);
    expect_obs(K_HADDR, "c1_haddr", 32'h20000000); expect_obs(K_HTRANS, "c1_htrans", 2);
    expect_obs(K_HMAST, "c1_hmaster", 0); expect_obs(K_M0RDY, "c1_m0rdy", 0);
    tick();
    drive_m1(HTRANS_NONSEQ, 32'h40000020, 1'b0, HBURST_SINGLE);
    expect_obs(K_HADDR, "c2_haddr", 32'h20000004); expect_obs(K_HTRANS, "c2_htrans", 3);
    expect_obs(K_M0RDY, "c2_m0rdy", 1); expect_obs(K_M1RDY, "c2_m1rdy", 1);
    tick();
    drive_m0(HTRANS_SEQ, 32'h20000008, 1'b0, INCR4);
    drive_m1(HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
    expect_obs(K_HADDR, "c3_haddr", 32'h20000008); expect_obs(K_HMAST, "c3_hmaster", 0);
    expect_obs(K_M1RDY, "c3_m1rdy", 0);
    tick();
    drive_m0(HTRANS_SEQ, 32'h2000000C, 1'b0, INCR4);
    expect_obs(K_HADDR, "c4_haddr", 32'h2000000C); expect_obs(K_HMAST, "c4_hmaster", 0);
    expect_obs(K_M1RDY, "c4_m1rdy", 0);
    tick();
    idle_both();
    expect_obs(K_HTRANS, "c5_htrans", 0); expect_obs(K_HMAST, "c5_hmaster", 0);
    expect_obs(K_M1RDY, "c5_m1rdy", 0); expect_obs(K_M0RDY, "c5_m0rdy", 1);
    tick();
    expect_obs(K_HADDR, "c6_haddr", 32'h40000020); expect_obs(K_HTRANS, "c6_htrans", 2);
    expect_obs(K_HMAST, "c6_hmaster", 1); expect_obs(K_M1RDY, "c6_m1rdy", 0);
    tick();
    expect_obs(K_M1RDY, "c7_m1rdy", 1); expect_obs(K_M0RDY, "c7_m0rdy", 1);
    tick();

    // D: two wait states on M1 data phase, M0 captured meanwhile
    drive_m1(HTRANS_NONSEQ, 32'h40000040, 1'b0, HBURST_SINGLE);
    expect_obs(K_HADDR, "d0_haddr", 32'h40000040); expect_obs(K_HMAST, "d0_hmaster", 1);
    expect_obs(K_M1RDY, "d0_m1rdy", 1);
    tick();
    drive_m1(HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
    drive_m0(HTRANS_NONSEQ, 32'h40010004, 1'b0, HBURST_SINGLE);
    HREADY = 1'b0;
    expect_obs(K_M1RDY, "d1_m1rdy", 0); expect_obs(K_M0RDY, "d1_m0rdy", 1);
    expect_obs(K_HTRANS, "d1_htrans", 0); expect_obs(K_HADDR, "d1_haddr", 0);
    tick();
    drive_m0(HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
    expect_obs(K_M1RDY, "d2_m1rdy", 0); expect_obs(K_M0RDY, "d2_m0rdy", 0);
    expect_obs(K_HMAST, "d2_hmaster", 1); expect_obs(K_HADDR, "d2_haddr", 0);
    tick();
    HREADY = 1'b1;
    expect_obs(K_M1RDY, "d3_m1rdy", 1); expect_obs(K_M0RDY, "d3_m0rdy", 0);
    expect_obs(K_HMAST, "d3_hmaster", 1);
    tick();
    expect_obs(K_HADDR, "d4_haddr", 32'h40010004); expect_obs(K_HTRANS, "d4_htrans", 2);
    expect_obs(K_HMAST, "d4_hmaster", 0); expect_obs(K_M0RDY, "d4_m0rdy", 0);
    tick();
    HRDATA = 32'h12345678;
    expect_obs(K_M0RDY, "d5_m0rdy", 1); expect_obs(K_M0RDAT, "d5_rdata", 32'h12345678);
    tick();

    // E: two-cycle ERROR on an M1 write
    drive_m1(HTRANS_NONSEQ, 32'h40000080, 1'b1, HBURST_SINGLE);
    expect_obs(K_HMAST, "e0_hmaster", 0); expect_obs(K_M1RDY, "e0_m1rdy", 1);
    tick();
    drive_m1(HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE); M1_HWDATA = 32'hE1E1E1E1;
    expect_obs(K_HADDR, "e1_haddr", 32'h40000080); expect_obs(K_HWRITE, "e1_hwrite", 1);
    expect_obs(K_HMAST, "e1_hmaster", 1); expect_obs(K_M1RDY, "e1_m1rdy", 0);
    tick();
    HREADY = 1'b0; HRESP = HRESP_ERROR;
    expect_obs(K_M1RESP, "e2_m1resp", 1); expect_obs(K_M1RDY, "e2_m1rdy", 0);
    expect_obs(K_M0RESP, "e2_m0resp", 0); expect_obs(K_HWDATA, "e2_hwdata", 32'hE1E1E1E1);
    tick();
    HREADY = 1'b1;
    expect_obs(K_M1RESP, "e3_m1resp", 1); expect_obs(K_M1RDY, "e3_m1rdy", 1);
    expect_obs(K_M0RESP, "e3_m0resp", 0);
    tick();
    HRESP = HRESP_OKAY;
    expect_obs(K_M1RESP, "e4_m1resp", 0);
    tick();

    // F: reset with an M1 hold pending and a data phase in flight
    drive_m0(HTRANS_NONSEQ, 32'h00000300, 1'b0, HBURST_SINGLE);
    expect_obs(K_HMAST, "f0_hmaster", 1); expect_obs(K_M0RDY, "f0_m0rdy", 1);
    tick();
    drive_m0(HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
    drive_m1(HTRANS_NONSEQ, 32'h40000100, 1'b0, HBURST_SINGLE);
    expect_obs(K_HADDR, "f1_haddr", 32'h00000300); expect_obs(K_HMAST, "f1_hmaster", 0);
    expect_obs(K_M0RDY, "f1_m0rdy", 0); expect_obs(K_M1RDY, "f1_m1rdy", 1);
    tick();
    idle_both(); HRESET = 1'b1;
    expect_obs(K_HMAST, "f2_hmaster", 1); expect_obs(K_M1RDY, "f2_m1rdy", 0);
    expect_obs(K_HADDR, "f2_haddr", 32'h40000100);
    tick();
    HRESET = 1'b0;
    drive_m0(HTRANS_NONSEQ, 32'h00000600, 1'b0, HBURST_SINGLE);
    expect_obs(K_HMAST, "f3_hmaster", 0); expect_obs(K_HTRANS, "f3_htrans", 2);
    expect_obs(K_HADDR, "f3_haddr", 32'h00000600); expect_obs(K_M0RDY, "f3_m0rdy", 1);
    expect_obs(K_M1RDY, "f3_m1rdy", 1); expect_obs(K_M1RESP, "f3_m1resp", 0);
    tick();
    idle_both();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
